serial_addsub: RTL
==================

Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor built around a single full-adder cell and a registered carry. Each accepted pair of WIDTH-bit operands is processed LSB-first over WIDTH cycles. Results carry cout and signed overflow. Valid/ready handshakes on both the input and output sides let it sit between area-constrained datapath stages.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand set a/b/cin/sub is valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A, unsigned/two's-complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (sub).
sub  input  1  0 = a+b+cin; 1 = a-b-cin.
out_valid  output  1  sum/cout/ovf valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry-out (add); NOT borrow (sub: 1 = no borrow).
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low, async): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0; bit counter=0; in_ready forced 0 while rst_n low, 1 from first edge-free moment after release.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On a clk edge with in_valid=1:
  - latch opA=a, opB=(sub ? ~b : b), carry=(sub ? ~cin : cin);
  - clear the result shift register and counter;
  - go to RUN.
- RUN: in_ready=0. Each edge, one bit step:
  - s = opA[0]^opB[0]^carry; carry <= opA[0]&opB[0] | (opA[0]^opB[0])&carry;
  - opA/opB shift right by one; s is shifted into the result MSB (result shifts right);
  - counter increments.
  - On the step where counter==WIDTH-1 (MSB step): record ovf = carry_in_to_MSB ^ carry_out_of_MSB; cout = final carry; go to DONE.
- DONE: out_valid=1, sum/cout/ovf stable and held. On an edge with out_ready=1, go to IDLE and clear out_valid. sum/cout/ovf keep their values until the next result loads.
- Latency: operands accepted on edge E0; out_valid is high after edge E0+WIDTH. Minimum issue interval is WIDTH+2 cycles with out_ready held high. There is no accept/retire overlap: in_ready is low throughout DONE.
- in_valid, a, b, cin and sub are ignored outside IDLE; changes to them during RUN must not affect the result.
- out_ready is ignored outside DONE.
- Backpressure: DONE is held indefinitely while out_ready=0; outputs do not change.
- Subtraction identity: a-b-cin = a + ~b + ~cin (mod 2^WIDTH). cout=0 indicates a borrow.
- Reset mid-RUN or mid-DONE: immediate abort to the reset values; the partial result is discarded; no out_valid pulse.
- Counter width is clog2(WIDTH). The counter never wraps in RUN.
- All outputs are registered except in_ready, which is decoded from state and gated by rst_n.

Test Plan:
- WIDTH=8, add 8'h35+8'h4A, cin=0 -> after 8 cycles out_valid=1, sum=8'h7F, cout=0, ovf=0; with out_ready=1, in_ready returns 1 two cycles later.
- Add 8'hFF+8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Add 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1. Add 8'hFF+8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- Sub 8'h10-8'h20, cin=0 -> sum=8'hF0, cout=0 (borrow), ovf=0. Sub 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1. Sub 8'h05-8'h05, cin=1 -> sum=8'hFF, cout=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE, toggle in_valid and a/b every cycle -> out_valid stays 1, sum unchanged, in_ready=0, no new op accepted. Release out_ready -> exactly one transfer.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 4 of RUN -> out_valid, sum, cout and ovf are 0 immediately. After release, in_ready=1 and a fresh 8'h01+8'h02 yields 8'h03 with no stale bits.
- Random/exhaustive: WIDTH=4, all 2*2*16*16 combinations of (sub, cin, a, b) compared against a reference model for sum, cout and ovf. Also 1000 random WIDTH=32 operations with out_ready randomly stalled.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry,
// LSB-first over WIDTH cycles, with valid/ready handshakes on both sides.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Single full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | ((x ^ y) & c), x ^ y ^ c};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       fa_s;
  logic [WIDTH-1:0] shifted_s;

  // Next-state and datapath step logic.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    fa_s        = full_add(opa_q[0], opb_q[0], carry_q);
    shifted_s   = {fa_s[0], res_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction runs as a + ~b + ~cin, so cout reads as "no borrow".
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = cin ^ sub;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = fa_s[1];
        res_d   = shifted_s[WIDTH-1:1];
        if (cnt_q == CW'(WIDTH - 1)) begin
          // MSB step: overflow is carry into the MSB xor carry out of it.
          sum_d       = shifted_s;
          cout_d      = fa_s[1];
          ovf_d       = carry_q ^ fa_s[1];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, operand, result and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
